video_timing: RTL
=================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameter COORD_WIDTH, 16, width of the coordinate outputs.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (H_TOTAL = 800).
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (V_TOTAL = 525).
REQ-004 Parameter LATENCY, 6, pixel-pipeline delay of the downstream colour generator in clocks.
REQ-005 pixel_clk  input  1  pixel clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 color  input  16  pixel colour from the rectangle renderer, valid LATENCY clocks after its coordinates.
REQ-008 x_coord  output  COORD_WIDTH  current horizontal counter, fed to the renderer.
REQ-009 y_coord  output  COORD_WIDTH  current vertical counter, fed to the renderer.
REQ-010 copy_start  output  1  one-cycle pulse at start of vertical blanking; triggers the renderer's rect copy.
REQ-011 hsync  output  1  horizontal sync, active-low, aligned to rgb.
REQ-012 vsync  output  1  vertical sync, active-low, aligned to rgb.
REQ-013 de  output  1  display enable, aligned to rgb.
REQ-014 rgb  output  16  output pixel, 5-6-5.

Function
REQ-015 h_cnt SHALL count 0..H_TOTAL-1 by one per clock and wrap 799->0.
REQ-016 v_cnt SHALL increment only on the h_cnt wrap, count 0..V_TOTAL-1, and wrap 524->0 on the same edge as the h_cnt wrap at h=799.
REQ-017 x_coord/y_coord SHALL be the registered h_cnt/v_cnt, zero-extended, with no added delay.
REQ-018 Raw active SHALL be (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE).
REQ-019 Raw hsync SHALL be 0 for h_cnt in [656, 751] and 1 otherwise.
REQ-020 Raw vsync SHALL be 0 for v_cnt in [490, 491] and 1 otherwise.
REQ-021 hsync, vsync and de SHALL be the raw signals delayed through exactly LATENCY flip-flop stages.
REQ-022 For LATENCY = 6: hsync low while h_cnt in [662, 757], and de high while h_cnt in [6, 645] of the line whose raw active was set.
REQ-023 rgb SHALL be color when de = 1, else 16'h0000, with no extra register.
REQ-024 copy_start SHALL be 1 for exactly the one cycle in which h_cnt = 0 and v_cnt = V_ACTIVE (480), and 0 otherwise.
REQ-025 copy_start SHALL be driven directly from a flip-flop (glitch-free).
REQ-026 copy_start SHALL occur once per frame, every 420000 clocks.
REQ-027 All timing constants SHALL derive from the parameters, with no hard-coded 640/480 in the logic.
REQ-028 Counter widths SHALL hold H_TOTAL-1 and V_TOTAL-1 without overflow.

Reset
REQ-029 While reset = 0, the block SHALL asynchronously force: h_cnt = 0, v_cnt = 0, every delay stage to its inactive value (hsync 1, vsync 1, de 0), and copy_start 0.
REQ-030 While reset = 0, outputs SHALL read x_coord = 0, y_coord = 0, hsync = 1, vsync = 1, de = 0, rgb = 0, copy_start = 0.
REQ-031 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-032 No partial sync pulse SHALL persist past reset assertion.
REQ-033 On the first rising edge after reset deasserts, h_cnt SHALL become 1.
REQ-034 The first LATENCY clocks after reset SHALL emit inactive hsync/vsync/de and rgb = 0, regardless of color.

Verification
REQ-035 Release reset, then run 800 clocks -> x_coord steps 0..799 and wraps to 0, y_coord goes 0->1 on that same edge, and de first goes high when x_coord = 6.
REQ-036 Hold color = 16'hF800 through a full line -> rgb = F800 for exactly 640 consecutive clocks while de = 1, and 0 elsewhere.
REQ-037 Measure hsync across one line -> low for exactly 96 clocks, first low while x_coord = 662.
REQ-038 Measure vsync across one frame -> low for exactly 2 x 800 clocks, starting on line 490 delayed by 6 clocks.
REQ-039 Run 2 frames -> copy_start pulses exactly twice, 420000 clocks apart, each while x_coord = 0 and y_coord = 480, each 1 clock wide.
REQ-040 Assert reset asynchronously mid-hsync at line 300 -> all outputs take their reset values before the next pixel_clk edge; after release, timing restarts from (0,0) and the first copy_start comes 384000 clocks later.

Source files
------------

// File: rtl/video_timing_if.sv
// Signal bundle between the video timing generator, the rectangle renderer and
// the display. The timing generator is the master: it drives the coordinates,
// the copy trigger and the display-side outputs, and receives the colour.
interface video_timing_if #(
  parameter int COORD_WIDTH = 16
);
  logic [15:0]            color;
  logic [COORD_WIDTH-1:0] x_coord;
  logic [COORD_WIDTH-1:0] y_coord;
  logic                   copy_start;
  logic                   hsync;
  logic                   vsync;
  logic                   de;
  logic [15:0]            rgb;

  modport master (
    input  color,
    output x_coord, y_coord, copy_start, hsync, vsync, de, rgb
  );

  modport slave (
    output color,
    input  x_coord, y_coord, copy_start, hsync, vsync, de, rgb
  );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator. Free-running h/v counters feed the renderer
// directly; sync and display-enable are delayed by LATENCY stages so that they
// line up with the renderer's colour output. copy_start marks the first clock
// of vertical blanking so the renderer can latch its next rectangle.
module video_timing #(
  parameter int COORD_WIDTH = 16,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LATENCY     = 6
) (
  input  logic           pixel_clk,
  input  logic           reset,
  video_timing_if.master vt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Control bundle per delay stage: {de, vsync, hsync}; idle = no DE, syncs high.
  localparam logic [2:0] CTL_IDLE = 3'b011;

  logic [HW-1:0]            h_cnt_q, h_cnt_d;
  logic [VW-1:0]            v_cnt_q, v_cnt_d;
  logic                     copy_start_q, copy_start_d;
  logic [LATENCY:1][2:0]    ctl_pipe_q, ctl_pipe_d;
  logic                     active_raw, hs_raw, vs_raw;

  // Raster counters: h wraps every line, v advances only on the h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Raw (undelayed) control decode from the current counter values.
  always_comb begin
    active_raw = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_raw     = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vs_raw     = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
  end

  // Delay line and copy trigger. copy_start is decoded one clock early so the
  // flop is high exactly while the counters read (0, V_ACTIVE).
  always_comb begin
    ctl_pipe_d    = '0;
    ctl_pipe_d[1] = {active_raw, vs_raw, hs_raw};
    for (int i = 2; i <= LATENCY; i++) ctl_pipe_d[i] = ctl_pipe_q[i-1];
    copy_start_d  = (h_cnt_q == H_LAST) && (v_cnt_q == V_ACT_LAST);
  end

  // All state, cleared asynchronously so a mid-frame reset kills any sync pulse.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      copy_start_q <= 1'b0;
      ctl_pipe_q   <= {LATENCY{CTL_IDLE}};
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      copy_start_q <= copy_start_d;
      ctl_pipe_q   <= ctl_pipe_d;
    end
  end

  assign vt.x_coord    = COORD_WIDTH'(h_cnt_q);
  assign vt.y_coord    = COORD_WIDTH'(v_cnt_q);
  assign vt.copy_start = copy_start_q;
  assign vt.hsync      = ctl_pipe_q[LATENCY][0];
  assign vt.vsync      = ctl_pipe_q[LATENCY][1];
  assign vt.de         = ctl_pipe_q[LATENCY][2];
  assign vt.rgb        = vt.de ? vt.color : 16'h0000;
endmodule
